// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM state, tag type
// and a constant log2 used to size port indices and FIFO pointers.
package sdram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_PORTS = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int TAG_W_MAX = clog2(MAX_PORTS);

    // Widest tag any legal configuration can need.
    typedef logic [TAG_W_MAX-1:0] tag_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundles the per-port Avalon-MM master buses and the single SDRAM-side bus.
// The arbiter uses the slave view; masters and the SDRAM controller use master.
interface sdram_port_arbiter_if #(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16
);
    logic [N_PORTS-1:0]          m_read;
    logic [N_PORTS-1:0]          m_write;
    logic [N_PORTS*ADDR_W-1:0]   m_address;
    logic [N_PORTS*DATA_W-1:0]   m_writedata;
    logic [N_PORTS*DATA_W/8-1:0] m_byteenable;
    logic [N_PORTS-1:0]          m_waitrequest;
    logic [DATA_W-1:0]           m_readdata;
    logic [N_PORTS-1:0]          m_readdatavalid;

    logic [ADDR_W-1:0]           avm_address;
    logic                        avm_read;
    logic                        avm_write;
    logic [DATA_W-1:0]           avm_writedata;
    logic [DATA_W/8-1:0]         avm_byteenable;
    logic                        avm_waitrequest;
    logic [DATA_W-1:0]           avm_readdata;
    logic                        avm_readdatavalid;

    modport slave (
        input  m_read, m_write, m_address, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport master (
        output m_read, m_write, m_address, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO holding the issuing port of every outstanding SDRAM read, in
// issue order; the head tag steers the returning readdatavalid strobe.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_tag,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_tag,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);
    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_tag = mem[rd_ptr];
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller Avalon-MM slave between
// N_PORTS masters, with a per-owner hold window and in-order read return routing.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N_PORTS     = 3,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4,
    parameter int HOLD        = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    sdram_port_arbiter_if.slave bus,
    output logic                err_sticky
);
    localparam int PORT_W = clog2(N_PORTS);
    localparam int BE_W   = DATA_W / 8;
    localparam int HOLD_W = clog2(HOLD + 1);
    localparam int CNT_W  = clog2(MAX_PENDING) + 1;

    arb_state_t         state;
    logic [PORT_W-1:0]  owner;
    logic [PORT_W-1:0]  rr_ptr;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [N_PORTS-1:0] req;
    logic               own_rd;
    logic               own_wr;
    logic               own_req;
    logic               throttle;
    logic               accept;
    logic               rd_accept;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PORT_W-1:0]  head_tag;
    logic [CNT_W-1:0]   pending;

    function automatic logic [PORT_W-1:0] next_idx(input logic [PORT_W-1:0] i);
        if (int'(i) == N_PORTS - 1) return '0;
        return i + 1'b1;
    endfunction

    function automatic logic [PORT_W-1:0] rr_pick(input logic [N_PORTS-1:0] r,
                                                  input logic [PORT_W-1:0]  ptr);
        logic [PORT_W-1:0] pick;
        logic              found;
        int                idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = (int'(ptr) + k) % N_PORTS;
            if (!found && r[idx]) begin
                pick  = PORT_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign req = bus.m_read | bus.m_write;

    always_comb begin
        own_rd  = bus.m_read[owner];
        own_wr  = bus.m_write[owner] & ~own_rd;
        own_req = own_rd | own_wr;
        pop     = bus.avm_readdatavalid & ~fifo_empty;
        // A pop in the same cycle frees a slot, so a full FIFO need not stall.
        throttle = own_rd & fifo_full & ~pop;

        bus.avm_read       = (state == GRANT) & own_rd & ~throttle;
        bus.avm_write      = (state == GRANT) & own_wr;
        bus.avm_address    = bus.m_address[int'(owner)*ADDR_W +: ADDR_W];
        bus.avm_writedata  = bus.m_writedata[int'(owner)*DATA_W +: DATA_W];
        bus.avm_byteenable = bus.m_byteenable[int'(owner)*BE_W +: BE_W];

        accept    = (bus.avm_read | bus.avm_write) & ~bus.avm_waitrequest;
        rd_accept = bus.avm_read & ~bus.avm_waitrequest;

        bus.m_waitrequest = '1;
        if (state == GRANT)
            bus.m_waitrequest[owner] = bus.avm_waitrequest | throttle | ~own_req;

        bus.m_readdatavalid = '0;
        if (pop) bus.m_readdatavalid[head_tag] = 1'b1;
        bus.m_readdata = bus.avm_readdata;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (bus.avm_readdatavalid && fifo_empty) err_sticky <= 1'b1;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= rr_pick(req, rr_ptr);
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!own_req || (accept && int'(hold_cnt) == HOLD - 1)) begin
                        rr_ptr   <= next_idx(owner);
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else if (accept) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (PORT_W)
    ) u_tag_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (rd_accept),
        .push_tag (owner),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending)
    );

    fifo_full_matches_count: assert property (
        @(posedge clk_clk) disable iff (!reset_reset_n)
        fifo_full == (int'(pending) == MAX_PENDING)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: an SDRAM responder model plus a
// scoreboard of expected read returns, and directed arbitration scenarios.
module tb_sdram_port_arbiter;
    localparam int N_PORTS     = 3;
    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 16;
    localparam int MAX_PENDING = 4;
    localparam int HOLD        = 4;
    localparam int RD_LAT      = 3;

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                cyc;
    } mdl_t;

    logic clk         = 1'b0;
    logic rst_n       = 1'b1;
    logic err_sticky;
    logic rsp_hold    = 1'b0;
    logic inject_spur = 1'b0;
    int   n_vec       = 0;
    int   n_err       = 0;
    int   cyc         = 0;

    exp_t exp_q[$];
    mdl_t mdl_q[$];
    int   acc_log[$];
    int   acc_cyc[$];

    sdram_port_arbiter_if #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_port_arbiter #(
        .N_PORTS     (N_PORTS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_PENDING (MAX_PENDING),
        .HOLD        (HOLD)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus),
        .err_sticky    (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        case (a)
            25'h100: return 16'hBEEF;
            25'h010: return 16'h1111;
            25'h020: return 16'h2222;
            default: return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    task automatic set_addr(input int p, input logic [ADDR_W-1:0] a);
        bus.m_address[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic wait_accept(input int p, output int waited);
        waited = 0;
        @(negedge clk);
        while (bus.m_waitrequest[p] && waited < 60) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 60) chk($sformatf("acc_timeout_p%0d", p), 32'(bus.m_waitrequest[p]), 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mdl_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic count_accepts(input int target);
        int k;
        int n;
        k = 0;
        n = 0;
        while (k < target && n < 60) begin
            @(negedge clk);
            n++;
            for (int p = 0; p < N_PORTS; p++)
                if (!bus.m_waitrequest[p] && (bus.m_read[p] || bus.m_write[p])) k++;
        end
        chk("accept_budget", 32'(k), 32'(target));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        acc_log.delete();
        acc_cyc.delete();
        rst_n = 1'b1;
    endtask

    // SDRAM controller model: fixed read latency, in-order return.
    initial begin : sdram_model
        mdl_t r;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                mdl_q.delete();
                bus.avm_readdatavalid = 1'b0;
            end else if (inject_spur) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = 16'hDEAD;
            end else if (!rsp_hold && mdl_q.size() > 0 && cyc >= mdl_q[0].cyc + RD_LAT) begin
                r = mdl_q.pop_front();
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = mem_word(r.addr);
            end else begin
                bus.avm_readdatavalid = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic [ADDR_W-1:0] pa;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.avm_readdatavalid) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rd_strobe", 32'(bus.m_readdatavalid), 32'(1 << e.port));
                        chk("rd_data", 32'(bus.m_readdata), 32'(e.data));
                    end else begin
                        chk("spur_mask", 32'(bus.m_readdatavalid), 32'd0);
                    end
                end else if (|bus.m_readdatavalid) begin
                    chk("stray_strobe", 32'(bus.m_readdatavalid), 32'd0);
                end
                for (int p = 0; p < N_PORTS; p++) begin
                    if (!bus.m_waitrequest[p] && (bus.m_read[p] || bus.m_write[p])) begin
                        pa = bus.m_address[p*ADDR_W +: ADDR_W];
                        acc_log.push_back(p);
                        acc_cyc.push_back(cyc);
                        chk($sformatf("acc_addr_p%0d", p), 32'(bus.avm_address), 32'(pa));
                        if (bus.m_read[p]) begin
                            chk("acc_rd", 32'(bus.avm_read), 32'd1);
                            exp_q.push_back('{p, mem_word(pa)});
                        end else begin
                            chk("acc_wr", 32'(bus.avm_write), 32'd1);
                            chk("wr_data", 32'(bus.avm_writedata), 32'(bus.m_writedata[p*DATA_W +: DATA_W]));
                            chk("wr_be", 32'(bus.avm_byteenable), 32'(bus.m_byteenable[p*2 +: 2]));
                        end
                    end
                end
                if (bus.avm_read && !bus.avm_waitrequest) mdl_q.push_back('{bus.avm_address, cyc});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected summary before timeout");
        $fatal(1);
    end

    initial begin : main
        int w;
        int n;
        int exp_seq[9];
        exp_seq = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
        bus.m_read          = '0;
        bus.m_write         = '0;
        bus.m_address       = '0;
        bus.m_writedata     = '0;
        bus.m_byteenable    = '0;
        bus.avm_waitrequest = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_waitreq", 32'(bus.m_waitrequest), 32'h7);
        chk("rst_rdv", 32'(bus.m_readdatavalid), 32'd0);
        chk("rst_avm_rd", 32'(bus.avm_read), 32'd0);
        chk("rst_avm_wr", 32'(bus.avm_write), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read from port 1
        @(posedge clk); #1;
        set_addr(1, 25'h100);
        bus.m_read[1] = 1'b1;
        wait_accept(1, w);
        chk("s1_arb_cycles", 32'(w), 32'd1);
        @(posedge clk); #1;
        bus.m_read[1] = 1'b0;
        n = 1;
        @(negedge clk);
        while (!(|bus.m_readdatavalid) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("s1_latency", 32'(n), 32'd3);
        chk("s1_strobe", 32'(bus.m_readdatavalid), 32'b010);
        chk("s1_data", 32'(bus.m_readdata), 32'hBEEF);
        chk("s1_err", 32'(err_sticky), 32'd0);
        wait_drain();

        // Continuous writes on ports 0 and 2, hold window rotation
        do_reset();
        set_addr(0, 25'h1000);
        set_addr(2, 25'h2000);
        bus.m_writedata[0*DATA_W +: DATA_W] = 16'h0A0A;
        bus.m_writedata[2*DATA_W +: DATA_W] = 16'h0C0C;
        bus.m_byteenable[0*2 +: 2] = 2'b01;
        bus.m_byteenable[2*2 +: 2] = 2'b10;
        bus.m_write[0] = 1'b1;
        bus.m_write[2] = 1'b1;
        count_accepts(9);
        @(posedge clk); #1;
        bus.m_write = '0;
        @(negedge clk);
        chk("s2_accepts", 32'(acc_log.size()), 32'd9);
        if (acc_log.size() >= 9) begin
            for (int i = 0; i < 9; i++)
                chk($sformatf("s2_grant%0d", i), 32'(acc_log[i]), 32'(exp_seq[i]));
            chk("s2_gap_same", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            chk("s2_gap_rot1", 32'(acc_cyc[4] - acc_cyc[3]), 32'd2);
            chk("s2_gap_rot2", 32'(acc_cyc[8] - acc_cyc[7]), 32'd2);
        end

        // Read throttle at MAX_PENDING with data withheld
        @(negedge clk);
        rsp_hold = 1'b1;
        @(posedge clk); #1;
        bus.m_read[0] = 1'b1;
        for (int i = 0; i < MAX_PENDING; i++) begin
            set_addr(0, ADDR_W'(32'h200 + i));
            wait_accept(0, w);
            @(posedge clk); #1;
        end
        set_addr(0, 25'h204);
        repeat (6) begin
            @(negedge clk);
            chk("s3_rd_blocked", 32'(bus.avm_read), 32'd0);
            chk("s3_stall", 32'(bus.m_waitrequest[0]), 32'd1);
        end
        rsp_hold = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.avm_readdatavalid && n < 10);
        chk("s3_pop_seen", 32'(bus.avm_readdatavalid), 32'd1);
        chk("s3_same_cycle", 32'({bus.avm_read, bus.m_waitrequest[0]}), 32'b10);
        @(posedge clk); #1;
        set_addr(0, 25'h205);
        wait_accept(0, w);
        chk("s3_6th_wait", 32'(w), 32'd0);
        @(posedge clk); #1;
        bus.m_read[0] = 1'b0;
        wait_drain();
        chk("s3_err", 32'(err_sticky), 32'd0);

        // Interleaved reads from ports 1 and 2, with an SDRAM stall first
        @(posedge clk); #1;
        bus.avm_waitrequest = 1'b1;
        set_addr(1, 25'h010);
        bus.m_read[1] = 1'b1;
        @(negedge clk);
        chk("s4_idle_stall", 32'(bus.m_waitrequest[1]), 32'd1);
        @(negedge clk);
        chk("s4_sdram_stall", 32'(bus.m_waitrequest[1]), 32'd1);
        chk("s4_avm_rd", 32'(bus.avm_read), 32'd1);
        @(posedge clk); #1;
        bus.avm_waitrequest = 1'b0;
        wait_accept(1, w);
        chk("s4_p1_wait", 32'(w), 32'd0);
        @(posedge clk); #1;
        bus.m_read[1] = 1'b0;
        set_addr(2, 25'h020);
        bus.m_read[2] = 1'b1;
        wait_accept(2, w);
        chk("s4_p2_wait", 32'(w), 32'd2);
        @(posedge clk); #1;
        bus.m_read[2] = 1'b0;
        wait_drain();

        // Spurious readdatavalid while idle
        @(negedge clk);
        inject_spur = 1'b1;
        @(negedge clk);
        inject_spur = 1'b0;
        chk("s5_mask", 32'(bus.m_readdatavalid), 32'd0);
        @(posedge clk); #1;
        chk("s5_err_set", 32'(err_sticky), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("s5_err_sticky", 32'(err_sticky), 32'd1);

        // Asynchronous reset in the middle of mixed traffic
        set_addr(0, 25'h3000);
        set_addr(1, 25'h040);
        bus.m_write[0] = 1'b1;
        bus.m_write[2] = 1'b1;
        bus.m_read[1]  = 1'b1;
        count_accepts(6);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("s6_waitreq", 32'(bus.m_waitrequest), 32'h7);
        chk("s6_rdv", 32'(bus.m_readdatavalid), 32'd0);
        chk("s6_avm_rd", 32'(bus.avm_read), 32'd0);
        chk("s6_avm_wr", 32'(bus.avm_write), 32'd0);
        chk("s6_err", 32'(err_sticky), 32'd0);
        bus.m_read  = '0;
        bus.m_write = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        acc_log.delete();
        acc_cyc.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_addr(2, 25'h030);
        bus.m_read[2] = 1'b1;
        wait_accept(2, w);
        chk("s6_post_wait", 32'(w), 32'd1);
        @(posedge clk); #1;
        bus.m_read[2] = 1'b0;
        wait_drain();
        chk("s6_post_err", 32'(err_sticky), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller Avalon-MM slave between N_PORTS on-chip masters: video fetch, sprite engine and CPU bridge.
- Round-robin grant, with an optional hold window that keeps SDRAM row locality for streaming masters.
- Tracks outstanding reads in a tag FIFO and routes pipelined readdata back to the issuing port.
- Sits between the masters and the SDRAM controller inside the SoC clock domain.

Parameters:
- N_PORTS, 3, number of requesting masters (2..8).
- ADDR_W, 25, word address width.
- DATA_W, 16, data width; byteenable width is DATA_W/8.
- MAX_PENDING, 4, maximum reads in flight (power of 2).
- HOLD, 4, maximum consecutive accepted transfers granted to one port before rotating.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- m_read  in  N_PORTS  per-port read request.
- m_write  in  N_PORTS  per-port write request.
- m_address  in  N_PORTS*ADDR_W  per-port address; port i occupies slice i.
- m_writedata  in  N_PORTS*DATA_W  per-port write data.
- m_byteenable  in  N_PORTS*DATA_W/8  per-port byte enables.
- m_waitrequest  out  N_PORTS  per-port stall; low only on that port's accept cycle.
- m_readdata  out  DATA_W  shared return data bus.
- m_readdatavalid  out  N_PORTS  one-hot return strobe.
- avm_address  out  ADDR_W  to SDRAM controller.
- avm_read  out  1  to SDRAM controller.
- avm_write  out  1  to SDRAM controller.
- avm_writedata  out  DATA_W  to SDRAM controller.
- avm_byteenable  out  DATA_W/8  to SDRAM controller.
- avm_waitrequest  in  1  from SDRAM controller.
- avm_readdata  in  DATA_W  from SDRAM controller.
- avm_readdatavalid  in  1  from SDRAM controller.
- err_sticky  out  1  set on an unexpected readdatavalid; cleared only by reset.

Behaviour:
- Reset: state IDLE, owner 0, rr pointer 0, hold count 0, FIFO empty. m_waitrequest all 1, m_readdatavalid 0, avm_read/avm_write 0, err_sticky 0.
- Port i requests when m_read[i]|m_write[i]. Asserting both is illegal; read wins.
- IDLE:
  - If any port requests, select the first requester at or after the rr pointer (wrapping at N_PORTS-1 -> 0).
  - Register it as owner, go to GRANT. Arbitration costs one cycle.
- GRANT:
  - avm_* mux the owner's command combinationally; m_waitrequest[owner] = avm_waitrequest.
  - Accept occurs when avm_read|avm_write and !avm_waitrequest. Each accept increments the hold count.
  - Rotate when the owner deasserts its request, or when an accept brings the hold count to HOLD. Set rr = owner+1 (mod N_PORTS), clear the hold count, go to IDLE.
  - Owner deasserting request without an accept is legal; rotate the same way.
- Read throttle: when pending == MAX_PENDING, force avm_read low. The owner stays stalled and the state stays GRANT; writes still pass.
- Tag FIFO:
  - Each read accept pushes the owner index.
  - Each avm_readdatavalid pops it, drives m_readdata = avm_readdata and m_readdatavalid[tag] = 1 in the same cycle (combinational, zero latency).
  - Simultaneous push and pop leaves the count unchanged. The pointers wrap modulo MAX_PENDING.
- avm_readdatavalid with the FIFO empty: set err_sticky, no pop, m_readdatavalid stays 0.
- Read data ordering is the SDRAM controller's in-order return. Ports may switch while reads are outstanding.
- Reset mid-operation drops all pending tags; the SDRAM controller shares the same reset.

Decomposition:
- Package sdram_arb_pkg: state enum (IDLE, GRANT), port-index width function clog2(N_PORTS), tag type.
- Sub-module sdram_arb_tag_fifo: MAX_PENDING-deep, width clog2(N_PORTS), with push, pop, full, empty and count outputs.
- Round-robin select and muxing stay in the top module.

Test Plan:
- Single port 1 read at 0x000100, avm_waitrequest low, readdatavalid 3 cycles later with 0xBEEF -> m_readdatavalid = 3'b010, m_readdata = 0xBEEF, err_sticky 0.
- Ports 0 and 2 issue continuous writes, HOLD = 4 -> grant sequence 0,0,0,0 then 2,2,2,2 then 0; one idle arbitration cycle between owners.
- Port 0 issues 6 back-to-back reads with readdatavalid withheld -> 4 accepted, avm_read low and m_waitrequest[0] high until the first readdatavalid; then the 5th is accepted the same cycle.
- Interleaved reads port 1 (0x10) then port 2 (0x20), data 0x1111 then 0x2222 -> strobes 3'b010 then 3'b100 in order.
- Push and pop in the same cycle with pending = 4 and a read accepted -> pending stays 4, no overflow.
- Spurious avm_readdatavalid at idle -> err_sticky = 1 and remains 1; pulse reset_reset_n low mid-burst -> all outputs return to reset values asynchronously.
